// File: rtl/fetch_decode_stage.sv
// Fetch/decode front end: owns the PC, fetches one instruction at a time,
// registers it and presents the immediate field and format select downstream.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [24:0] out_imm,
  output logic [2:0]  out_imm_src,
  output logic        out_illegal
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        discard;
  logic [31:0] tgt;
  logic [2:0]  dec_src;
  logic        dec_ill;
  logic [2:0]  f3;

  assign tgt            = redirect_pc & ~32'h3;
  assign imem_addr      = pc;
  assign imem_req_valid = (state == REQ) & ~redirect_valid & ~reset;
  assign out_imm        = out_instr[31:7];
  assign f3             = imem_rdata[14:12];

  // every legal opcode ends in 2'b11, so the default also covers bad [1:0]
  always_comb begin
    dec_src = 3'b000;
    dec_ill = 1'b0;
    case (imem_rdata[6:0])
      7'b0000011,
      7'b1100111,
      7'b0110011: dec_src = 3'b000;
      7'b0010011: dec_src = (f3 == 3'b001 || f3 == 3'b101) ? 3'b101 : 3'b000;
      7'b0100011: dec_src = 3'b001;
      7'b1100011: dec_src = 3'b010;
      7'b1101111: dec_src = 3'b011;
      7'b0110111,
      7'b0010111: dec_src = 3'b100;
      default:    dec_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= REQ;
      pc          <= RESET_PC;
      discard     <= 1'b0;
      out_valid   <= 1'b0;
      out_pc      <= 32'h0;
      out_instr   <= NOP_INSTR;
      out_imm_src <= 3'b000;
      out_illegal <= 1'b0;
    end else begin
      unique case (state)
        REQ: begin
          if (redirect_valid) begin
            pc <= tgt;
          end else if (imem_req_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            pc <= tgt;
            if (imem_rsp_valid) begin
              discard <= 1'b0;
              state   <= REQ;
            end else begin
              discard <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= REQ;
            end else begin
              out_instr   <= imem_rdata;
              out_pc      <= pc;
              out_imm_src <= dec_src;
              out_illegal <= dec_ill;
              out_valid   <= 1'b1;
              state       <= HOLD;
            end
          end
        end
        HOLD: begin
          // a redirect squashes the held instruction and wins over out_ready
          if (redirect_valid) begin
            pc          <= tgt;
            out_valid   <= 1'b0;
            out_instr   <= NOP_INSTR;
            out_imm_src <= 3'b000;
            out_illegal <= 1'b0;
            state       <= REQ;
          end else if (out_ready) begin
            pc        <= pc + 32'd4;
            out_valid <= 1'b0;
            state     <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule
